square_channel_ctrl: RTL and testbench

SQUARE_CHANNEL_CTRL -- requirements
Module: square_channel_ctrl

---
 rtl/square_channel_ctrl_pkg.sv | 51 +++++
 rtl/sound_envelope.sv | 49 ++++
 rtl/square_channel_ctrl.sv | 157 +++++++++++++++
 tb/tb_square_channel_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/square_channel_ctrl_pkg.sv
// Shared definitions for the square channel controller: register map, frame-step
// decode masks, field widths and the frequency-sweep arithmetic.
package square_channel_ctrl_pkg;

  localparam int FREQ_W = 11;
  localparam int VOL_W  = 4;
  localparam int LEN_W  = 7;

  localparam logic [2:0] ADDR_SWEEP    = 3'd0;
  localparam logic [2:0] ADDR_DUTY_LEN = 3'd1;
  localparam logic [2:0] ADDR_ENVELOPE = 3'd2;
  localparam logic [2:0] ADDR_FREQ_LO  = 3'd3;
  localparam logic [2:0] ADDR_FREQ_HI  = 3'd4;

  // Bit n set means frame step n produces that clock.
  localparam logic [7:0] LEN_STEPS   = 8'b0101_0101;
  localparam logic [7:0] SWEEP_STEPS = 8'b0100_0100;
  localparam logic [2:0] ENV_STEP    = 3'd7;

  typedef struct packed {
    logic [2:0] period;
    logic       negate;
    logic [2:0] shift;
  } sweep_cfg_t;

  typedef struct packed {
    logic [VOL_W-1:0] init_vol;
    logic             up;
    logic [2:0]       period;
  } env_cfg_t;

  // 12-bit so an upward overflow shows in bit 11; subtraction cannot underflow.
  function automatic logic [11:0] sweep_calc(input logic [FREQ_W-1:0] shadow,
                                             input logic negate,
                                             input logic [2:0] shift);
    logic [11:0] base;
    logic [11:0] delta;
    base  = {1'b0, shadow};
    delta = base >> shift;
    return negate ? (base - delta) : (base + delta);
  endfunction

  function automatic logic sweep_overflows(input logic [FREQ_W-1:0] shadow,
                                           input logic negate,
                                           input logic [2:0] shift);
    logic [11:0] res;
    res = sweep_calc(shadow, negate, shift);
    return res[11];
  endfunction

endpackage

// File: rtl/sound_envelope.sv
// Volume envelope shared by the sound channels: period timer, saturating
// volume step and trigger reload.
module sound_envelope
  import square_channel_ctrl_pkg::*;
(
  input  logic             I_BITCLK,
  input  logic             I_RESET_N,
  input  logic             env_clk,
  input  logic             trigger,
  input  env_cfg_t         cfg,
  output logic [VOL_W-1:0] volume
);

  logic [2:0]       timer_reg, timer_next;
  logic [VOL_W-1:0] vol_reg, vol_next;

  always_comb begin
    timer_next = timer_reg;
    vol_next   = vol_reg;
    if (trigger) begin
      timer_next = cfg.period;
      vol_next   = cfg.init_vol;
    end else if (env_clk && (cfg.period != 3'd0)) begin
      // A timer of 0 (never loaded) expires on its first clock rather than wrapping.
      if (timer_reg <= 3'd1) begin
        timer_next = cfg.period;
        if (cfg.up && (vol_reg != 4'd15))
          vol_next = vol_reg + 4'd1;
        else if (!cfg.up && (vol_reg != 4'd0))
          vol_next = vol_reg - 4'd1;
      end else begin
        timer_next = timer_reg - 3'd1;
      end
    end
  end

  always_ff @(posedge I_BITCLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      timer_reg <= '0;
      vol_reg   <= '0;
    end else begin
      timer_reg <= timer_next;
      vol_reg   <= vol_next;
    end
  end

  assign volume = vol_reg;

endmodule

// File: rtl/square_channel_ctrl.sv
// Square-wave channel control: register file, frame sequencer, length counter
// and frequency sweep; the envelope lives in sound_envelope.
module square_channel_ctrl
  import square_channel_ctrl_pkg::*;
(
  input  logic              I_BITCLK,
  input  logic              I_RESET_N,
  input  logic              I_FRAME_TICK,
  input  logic              I_WR_EN,
  input  logic [2:0]        I_WR_ADDR,
  input  logic [7:0]        I_WR_DATA,
  output logic [FREQ_W-1:0] O_FREQUENCY,
  output logic [1:0]        O_DUTY_CYCLE,
  output logic [VOL_W-1:0]  O_VOLUME,
  output logic              O_WAVEFORM_EN,
  output logic              O_ACTIVE
);

  sweep_cfg_t        sweep_cfg_reg, sweep_cfg_next;
  env_cfg_t          env_cfg_reg, env_cfg_next;
  logic [1:0]        duty_reg, duty_next;
  logic              len_en_reg, len_en_next;
  logic [FREQ_W-1:0] freq_reg, freq_next;
  logic [FREQ_W-1:0] shadow_reg, shadow_next;
  logic [3:0]        sweep_timer_reg, sweep_timer_next;
  logic [LEN_W-1:0]  length_cnt_reg, length_cnt_next;
  logic [2:0]        step_reg;
  logic              enable_reg, enable_next;

  logic wr_sweep, wr_duty, wr_env, wr_lo, wr_hi, trigger;
  logic len_clk, sweep_clk, env_clk;
  logic [3:0]  sweep_reload;
  logic [11:0] calc_a;
  logic sweep_ovf, trig_ovf, len_expire, dac_on_next;

  assign wr_sweep = I_WR_EN && (I_WR_ADDR == ADDR_SWEEP);
  assign wr_duty  = I_WR_EN && (I_WR_ADDR == ADDR_DUTY_LEN);
  assign wr_env   = I_WR_EN && (I_WR_ADDR == ADDR_ENVELOPE);
  assign wr_lo    = I_WR_EN && (I_WR_ADDR == ADDR_FREQ_LO);
  assign wr_hi    = I_WR_EN && (I_WR_ADDR == ADDR_FREQ_HI);
  assign trigger  = wr_hi && I_WR_DATA[7];

  // Clocks are decoded from the step value before this tick's increment.
  assign len_clk   = I_FRAME_TICK && LEN_STEPS[step_reg];
  assign sweep_clk = I_FRAME_TICK && SWEEP_STEPS[step_reg];
  assign env_clk   = I_FRAME_TICK && (step_reg == ENV_STEP);

  assign sweep_reload = (sweep_cfg_reg.period == 3'd0) ? 4'd8 : {1'b0, sweep_cfg_reg.period};

  always_comb begin
    sweep_cfg_next = sweep_cfg_reg;
    env_cfg_next   = env_cfg_reg;
    duty_next      = duty_reg;
    len_en_next    = len_en_reg;
    if (wr_sweep) sweep_cfg_next = I_WR_DATA[6:0];
    if (wr_env)   env_cfg_next   = I_WR_DATA;
    if (wr_duty)  duty_next      = I_WR_DATA[7:6];
    if (wr_hi)    len_en_next    = I_WR_DATA[6];
  end

  always_comb begin
    freq_next        = freq_reg;
    shadow_next      = shadow_reg;
    sweep_timer_next = sweep_timer_reg;
    calc_a           = '0;
    sweep_ovf        = 1'b0;
    trig_ovf         = 1'b0;
    if (wr_lo) freq_next[7:0]  = I_WR_DATA;
    if (wr_hi) freq_next[10:8] = I_WR_DATA[2:0];
    if (trigger) begin
      shadow_next      = freq_next;
      sweep_timer_next = sweep_reload;
      trig_ovf         = (sweep_cfg_reg.shift != 3'd0) &&
                         sweep_overflows(freq_next, sweep_cfg_reg.negate, sweep_cfg_reg.shift);
    end else if (sweep_clk) begin
      if (sweep_timer_reg <= 4'd1) begin
        sweep_timer_next = sweep_reload;
        if (sweep_cfg_reg.period != 3'd0) begin
          calc_a = sweep_calc(shadow_reg, sweep_cfg_reg.negate, sweep_cfg_reg.shift);
          if (calc_a[11]) begin
            sweep_ovf = 1'b1;
          end else if (sweep_cfg_reg.shift != 3'd0) begin
            shadow_next = calc_a[FREQ_W-1:0];
            // A same-cycle frequency write is the later writer of the output.
            if (!(wr_lo || wr_hi)) freq_next = calc_a[FREQ_W-1:0];
            sweep_ovf = sweep_overflows(calc_a[FREQ_W-1:0], sweep_cfg_reg.negate,
                                        sweep_cfg_reg.shift);
          end
        end
      end else begin
        sweep_timer_next = sweep_timer_reg - 4'd1;
      end
    end
  end

  always_comb begin
    length_cnt_next = length_cnt_reg;
    len_expire      = 1'b0;
    if (wr_duty) begin
      length_cnt_next = 7'd64 - {1'b0, I_WR_DATA[5:0]};
    end else if (trigger && (length_cnt_reg == '0)) begin
      length_cnt_next = 7'd64;
    end else if (len_clk && len_en_reg && (length_cnt_reg != '0)) begin
      length_cnt_next = length_cnt_reg - 7'd1;
      len_expire      = (length_cnt_reg == 7'd1);
    end
  end

  always_comb begin
    dac_on_next = (env_cfg_next.init_vol != 4'd0) || env_cfg_next.up;
    enable_next = enable_reg;
    if (len_expire || sweep_ovf) enable_next = 1'b0;
    if (trigger)                 enable_next = !trig_ovf;
    if (!dac_on_next)            enable_next = 1'b0;
  end

  always_ff @(posedge I_BITCLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      sweep_cfg_reg   <= '0;
      env_cfg_reg     <= '0;
      duty_reg        <= '0;
      len_en_reg      <= 1'b0;
      freq_reg        <= '0;
      shadow_reg      <= '0;
      sweep_timer_reg <= '0;
      length_cnt_reg  <= '0;
      step_reg        <= '0;
      enable_reg      <= 1'b0;
    end else begin
      sweep_cfg_reg   <= sweep_cfg_next;
      env_cfg_reg     <= env_cfg_next;
      duty_reg        <= duty_next;
      len_en_reg      <= len_en_next;
      freq_reg        <= freq_next;
      shadow_reg      <= shadow_next;
      sweep_timer_reg <= sweep_timer_next;
      length_cnt_reg  <= length_cnt_next;
      enable_reg      <= enable_next;
      if (I_FRAME_TICK) step_reg <= step_reg + 3'd1;
    end
  end

  sound_envelope u_envelope (
    .I_BITCLK  (I_BITCLK),
    .I_RESET_N (I_RESET_N),
    .env_clk   (env_clk),
    .trigger   (trigger),
    .cfg       (env_cfg_reg),
    .volume    (O_VOLUME)
  );

  assign O_FREQUENCY   = freq_reg;
  assign O_DUTY_CYCLE  = duty_reg;
  assign O_WAVEFORM_EN = enable_reg;
  assign O_ACTIVE      = enable_reg;

endmodule

// File: tb/tb_square_channel_ctrl.sv
// Directed bench for square_channel_ctrl: expected outputs are queued as each
// step is driven and compared once the registered result appears.
module tb_square_channel_ctrl;

  logic        I_BITCLK = 1'b0;
  logic        I_RESET_N = 1'b1;
  logic        I_FRAME_TICK = 1'b0;
  logic        I_WR_EN = 1'b0;
  logic [2:0]  I_WR_ADDR = 3'd0;
  logic [7:0]  I_WR_DATA = 8'd0;
  logic [10:0] O_FREQUENCY;
  logic [1:0]  O_DUTY_CYCLE;
  logic [3:0]  O_VOLUME;
  logic        O_WAVEFORM_EN;
  logic        O_ACTIVE;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [10:0] freq;
    logic [1:0]  duty;
    logic [3:0]  vol;
    logic        en;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];

  square_channel_ctrl dut (
    .I_BITCLK      (I_BITCLK),
    .I_RESET_N     (I_RESET_N),
    .I_FRAME_TICK  (I_FRAME_TICK),
    .I_WR_EN       (I_WR_EN),
    .I_WR_ADDR     (I_WR_ADDR),
    .I_WR_DATA     (I_WR_DATA),
    .O_FREQUENCY   (O_FREQUENCY),
    .O_DUTY_CYCLE  (O_DUTY_CYCLE),
    .O_VOLUME      (O_VOLUME),
    .O_WAVEFORM_EN (O_WAVEFORM_EN),
    .O_ACTIVE      (O_ACTIVE)
  );

  always #5 I_BITCLK = ~I_BITCLK;

  task automatic push_exp(input string tag, input logic [10:0] f, input logic [1:0] d,
                          input logic [3:0] v, input logic e);
    exp_t x;
    x.freq = f; x.duty = d; x.vol = v; x.en = e;
    exp_q.push_back(x);
    tag_q.push_back(tag);
  endtask

  task automatic check_out();
    exp_t  x;
    string tag;
    logic [18:0] obs, want;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: observed no entry required one");
      return;
    end
    x   = exp_q.pop_front();
    tag = tag_q.pop_front();
    obs  = {O_FREQUENCY, O_DUTY_CYCLE, O_VOLUME, O_WAVEFORM_EN, O_ACTIVE};
    want = {x.freq, x.duty, x.vol, x.en, x.en};
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed freq=%h duty=%0d vol=%0d en=%b active=%b, expected freq=%h duty=%0d vol=%0d en=%b active=%b",
             tag, O_FREQUENCY, O_DUTY_CYCLE, O_VOLUME, O_WAVEFORM_EN, O_ACTIVE,
             x.freq, x.duty, x.vol, x.en, x.en);
    end
    $display("check %s: freq=%h duty=%0d vol=%0d en=%b", tag, O_FREQUENCY, O_DUTY_CYCLE,
             O_VOLUME, O_WAVEFORM_EN);
  endtask

  task automatic exp_chk(input string tag, input logic [10:0] f, input logic [1:0] d,
                         input logic [3:0] v, input logic e);
    push_exp(tag, f, d, v, e);
    check_out();
  endtask

  // All drive tasks start and end 1 time unit after a rising edge.
  task automatic wr(input logic [2:0] a, input logic [7:0] d, input logic tk = 1'b0);
    I_WR_EN = 1'b1; I_WR_ADDR = a; I_WR_DATA = d; I_FRAME_TICK = tk;
    @(posedge I_BITCLK); #1;
    I_WR_EN = 1'b0; I_FRAME_TICK = 1'b0;
  endtask

  task automatic tick();
    I_FRAME_TICK = 1'b1;
    @(posedge I_BITCLK); #1;
    I_FRAME_TICK = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    I_RESET_N = 1'b0;
    #2;
    exp_chk(tag, 11'h000, 2'd0, 4'd0, 1'b0);
    @(negedge I_BITCLK);
    I_RESET_N = 1'b1;
    @(posedge I_BITCLK); #1;
  endtask

  initial begin
    logic [10:0] sweep_exp [7];
    int env_vol;
    sweep_exp = '{11'h100, 11'h100, 11'h180, 11'h180, 11'h180, 11'h180, 11'h240};

    #1;
    do_reset("reset_initial");

    // Length expiry: length_cnt=2 runs out on the step-2 tick
    wr(3'd1, 8'hBE);            exp_chk("len_wr_duty", 11'h000, 2'd2, 4'd0, 1'b0);
    wr(3'd2, 8'hF0);            exp_chk("len_wr_env", 11'h000, 2'd2, 4'd0, 1'b0);
    wr(3'd4, 8'hC0);            exp_chk("len_trigger", 11'h000, 2'd2, 4'd15, 1'b1);
    tick();                     exp_chk("len_step0", 11'h000, 2'd2, 4'd15, 1'b1);
    tick();                     exp_chk("len_step1", 11'h000, 2'd2, 4'd15, 1'b1);
    tick();                     exp_chk("len_step2_expire", 11'h000, 2'd2, 4'd15, 1'b0);
    tick();                     exp_chk("len_step3", 11'h000, 2'd2, 4'd15, 1'b0);

    // DAC off: trigger cannot enable, and clearing the DAC disables a live channel
    wr(3'd2, 8'h00);            exp_chk("dac_off_wr", 11'h000, 2'd2, 4'd15, 1'b0);
    wr(3'd4, 8'h80);            exp_chk("dac_off_trigger", 11'h000, 2'd2, 4'd0, 1'b0);
    wr(3'd2, 8'h08);            exp_chk("dac_up_only_wr", 11'h000, 2'd2, 4'd0, 1'b0);
    wr(3'd4, 8'h80);            exp_chk("dac_up_only_trigger", 11'h000, 2'd2, 4'd0, 1'b1);
    wr(3'd2, 8'h00);            exp_chk("dac_off_live", 11'h000, 2'd2, 4'd0, 1'b0);

    // Sweep up from 0x100 with shift 1, period 1
    do_reset("reset_before_sweep");
    wr(3'd0, 8'h11);            exp_chk("sweep_wr_cfg", 11'h000, 2'd0, 4'd0, 1'b0);
    wr(3'd2, 8'hF0);            exp_chk("sweep_wr_env", 11'h000, 2'd0, 4'd0, 1'b0);
    wr(3'd3, 8'h00);            exp_chk("sweep_wr_lo", 11'h000, 2'd0, 4'd0, 1'b0);
    wr(3'd4, 8'h81);            exp_chk("sweep_trigger", 11'h100, 2'd0, 4'd15, 1'b1);
    for (int i = 0; i < 7; i++) begin
      tick();
      exp_chk($sformatf("sweep_step%0d", i), sweep_exp[i], 2'd0, 4'd15, 1'b1);
    end

    // Asynchronous reset in the middle of a sweep, checked before any edge
    do_reset("reset_mid_sweep");

    // Overflow on the trigger check itself
    wr(3'd0, 8'h11);            exp_chk("ovf_wr_cfg", 11'h000, 2'd0, 4'd0, 1'b0);
    wr(3'd2, 8'hF0);            exp_chk("ovf_wr_env", 11'h000, 2'd0, 4'd0, 1'b0);
    wr(3'd3, 8'hFF);            exp_chk("ovf_wr_lo", 11'h0FF, 2'd0, 4'd0, 1'b0);
    wr(3'd4, 8'h87);            exp_chk("ovf_trigger_7ff", 11'h7FF, 2'd0, 4'd15, 1'b0);

    // Overflow found only by the second check after a sweep update
    wr(3'd3, 8'h00);            exp_chk("ovf2_wr_lo", 11'h700, 2'd0, 4'd15, 1'b0);
    wr(3'd4, 8'h85);            exp_chk("ovf2_trigger", 11'h500, 2'd0, 4'd15, 1'b1);
    tick();                     exp_chk("ovf2_step0", 11'h500, 2'd0, 4'd15, 1'b1);
    tick();                     exp_chk("ovf2_step1", 11'h500, 2'd0, 4'd15, 1'b1);
    tick();                     exp_chk("ovf2_step2", 11'h780, 2'd0, 4'd15, 1'b0);

    // Negate never overflows, even from 0x7FF
    wr(3'd0, 8'h19);            exp_chk("neg_wr_cfg", 11'h780, 2'd0, 4'd15, 1'b0);
    wr(3'd3, 8'hFF);            exp_chk("neg_wr_lo", 11'h7FF, 2'd0, 4'd15, 1'b0);
    wr(3'd4, 8'h87);            exp_chk("neg_trigger", 11'h7FF, 2'd0, 4'd15, 1'b1);
    for (int s = 3; s < 7; s++) begin
      tick();
      exp_chk($sformatf("neg_step%0d", s), (s == 6) ? 11'h400 : 11'h7FF, 2'd0, 4'd15, 1'b1);
    end

    // Envelope down from 3, period 1, saturating at 0
    do_reset("reset_before_env");
    wr(3'd2, 8'h31);            exp_chk("env_wr", 11'h000, 2'd0, 4'd0, 1'b0);
    wr(3'd4, 8'h80);            exp_chk("env_trigger", 11'h000, 2'd0, 4'd3, 1'b1);
    env_vol = 3;
    for (int i = 0; i < 32; i++) begin
      tick();
      if (((i % 8) == 7) && (env_vol > 0)) env_vol--;
      exp_chk($sformatf("env_tick%0d", i), 11'h000, 2'd0, 4'(env_vol), 1'b1);
    end

    // Trigger coinciding with the step-7 tick loads init volume
    wr(3'd2, 8'hA1);            exp_chk("col_wr_env", 11'h000, 2'd0, 4'd0, 1'b1);
    for (int i = 0; i < 7; i++) tick();
    exp_chk("col_pre_steps", 11'h000, 2'd0, 4'd0, 1'b1);
    wr(3'd4, 8'h80, 1'b1);      exp_chk("col_trigger_step7", 11'h000, 2'd0, 4'd10, 1'b1);
    for (int i = 0; i < 8; i++) begin
      tick();
      exp_chk($sformatf("col_tick%0d", i), 11'h000, 2'd0, (i == 7) ? 4'd9 : 4'd10, 1'b1);
    end

    // Writes to unused addresses change nothing
    wr(3'd5, 8'hFF);            exp_chk("ignored_addr5", 11'h000, 2'd0, 4'd9, 1'b1);
    wr(3'd7, 8'h3F);            exp_chk("ignored_addr7", 11'h000, 2'd0, 4'd9, 1'b1);

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover: observed %0d entries required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish required finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
